// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single shared memory port.
// Instruction fetch and data memory compete for the port. When both request
// at once, the one that did not own the port last time wins. Each access lasts
// LATENCY cycles and is followed by at least one IDLE cycle.
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic        dm_we,
  output logic        if_gnt,
  output logic        dm_gnt,
  output logic        if_done,
  output logic        dm_done,
  output logic        mem_sel,
  output logic [31:0] mem_addr,
  output logic        mem_en,
  output logic        mem_we
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic        sel_q, sel_d;       // 0 = fetch owns, 1 = data owns
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;     // owner of the most recently completed access
  logic        grant_dm;
  logic        in_access;
  logic        done_w;

  // Next-state, arbitration and access-counter logic.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    grant_dm = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          // Data wins if it is alone, or on a tie when fetch owned last.
          grant_dm = dm_req && (!if_req || !last_q);
          state_d  = ACCESS;
          sel_d    = grant_dm;
          addr_d   = grant_dm ? dm_addr : if_addr;
          we_d     = grant_dm && dm_we;
          cnt_d    = CNT_INIT;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          last_d  = sel_q;
          we_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign in_access = (state_q == ACCESS);
  assign done_w    = in_access && (cnt_q == 4'd0);
  assign if_gnt    = in_access && !sel_q;
  assign dm_gnt    = in_access && sel_q;
  assign if_done   = done_w && !sel_q;
  assign dm_done   = done_w && sel_q;
  assign mem_sel   = sel_q;
  assign mem_addr  = addr_q;
  assign mem_en    = in_access;
  assign mem_we    = we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (LATENCY 2, 4, 1),
// a scoreboard of expected accesses and a negedge monitor that checks them.
module tb_mem_port_arbiter;

  function automatic int unsigned lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 4 : 1;
  endfunction

  typedef struct {
    int          dut;
    logic        owner;
    logic [31:0] addr;
    logic        we;
    int          len;
    int          gap;
    logic        abort;
  } txn_t;

  logic        clk;
  logic        rst_n   [3];
  logic        if_req  [3];
  logic [31:0] if_addr [3];
  logic        dm_req  [3];
  logic [31:0] dm_addr [3];
  logic        dm_we   [3];
  logic        if_gnt  [3];
  logic        dm_gnt  [3];
  logic        if_done [3];
  logic        dm_done [3];
  logic        mem_sel [3];
  logic [31:0] mem_addr[3];
  logic        mem_en  [3];
  logic        mem_we  [3];

  int   nchk = 0;
  int   nerr = 0;
  txn_t sbq[$];
  txn_t cur[3];
  bit   act[3];
  int   run_c[3];
  int   idle_c[3];
  int   done_c[3];
  logic g, d;

  for (genvar gi = 0; gi < 3; gi++) begin : gen_dut
    mem_port_arbiter #(.LATENCY(lat_of(gi))) u_dut (
      .clk     (clk),
      .rst_n   (rst_n[gi]),
      .if_req  (if_req[gi]),
      .if_addr (if_addr[gi]),
      .dm_req  (dm_req[gi]),
      .dm_addr (dm_addr[gi]),
      .dm_we   (dm_we[gi]),
      .if_gnt  (if_gnt[gi]),
      .dm_gnt  (dm_gnt[gi]),
      .if_done (if_done[gi]),
      .dm_done (dm_done[gi]),
      .mem_sel (mem_sel[gi]),
      .mem_addr(mem_addr[gi]),
      .mem_en  (mem_en[gi]),
      .mem_we  (mem_we[gi])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic owner, input logic [31:0] addr,
                      input logic we, input int gap, input logic abort);
    txn_t t;
    t.dut = k; t.owner = owner; t.addr = addr; t.we = we;
    t.len = int'(lat_of(k)); t.gap = gap; t.abort = abort;
    sbq.push_back(t);
  endtask

  // Waits (bounded) until instance k has completed 'target' accesses.
  task automatic wait_done(input int k, input int target);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (done_c[k] >= target) break;
    end
    chk("done_count", done_c[k], target);
  endtask

  // Monitor: pops an expected access at each grant start and checks it at done.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      g = if_gnt[k] | dm_gnt[k];
      d = if_done[k] | dm_done[k];
      if (!rst_n[k]) begin
        if (act[k]) chk("abort_expected", cur[k].abort, 1'b1);
        act[k] = 1'b0;
      end else begin
        chk("gnt_excl", if_gnt[k] & dm_gnt[k], 1'b0);
        if (g && !act[k]) begin
          chk("sb_has_txn", sbq.size() > 0, 1'b1);
          if (sbq.size() > 0) begin
            cur[k] = sbq.pop_front();
            chk("txn_dut", k, cur[k].dut);
            if (cur[k].gap >= 0) chk("idle_gap", idle_c[k], cur[k].gap);
            act[k]   = 1'b1;
            run_c[k] = 0;
          end
        end
        if (act[k]) begin
          run_c[k]++;
          chk("access_outs", {g, mem_en[k], dm_gnt[k], mem_sel[k], mem_addr[k], mem_we[k]},
              {1'b1, 1'b1, cur[k].owner, cur[k].owner, cur[k].addr, cur[k].we});
        end
        if (d) begin
          chk("done_in_access", act[k], 1'b1);
          chk("done_excl", if_done[k] & dm_done[k], 1'b0);
          if (act[k]) begin
            chk("done_owner", dm_done[k], cur[k].owner);
            chk("access_len", run_c[k], cur[k].len);
            chk("done_not_aborted", cur[k].abort, 1'b0);
          end
          act[k]    = 1'b0;
          idle_c[k] = 0;
          done_c[k]++;
        end
        if (!g) begin
          idle_c[k]++;
          act[k] = 1'b0;
          chk("idle_outs", {mem_en[k], mem_we[k], if_done[k], dm_done[k]}, 4'b0000);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; if_req[k] = 1'b0; dm_req[k] = 1'b0; dm_we[k] = 1'b0;
      if_addr[k] = '0; dm_addr[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk("reset_outs", {if_gnt[k], dm_gnt[k], if_done[k], dm_done[k], mem_sel[k],
                         mem_en[k], mem_we[k], mem_addr[k]}, 64'd0);
    #1;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

    // Single fetch, LATENCY 2.
    push(0, 1'b0, 32'h0040_0000, 1'b0, -1, 1'b0);
    if_req[0] = 1'b1; if_addr[0] = 32'h0040_0000;
    @(negedge clk);
    chk("fetch_c1", {if_gnt[0], dm_gnt[0], if_done[0], mem_sel[0], mem_en[0], mem_addr[0]},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0040_0000});
    #1 if_req[0] = 1'b0;
    @(negedge clk);
    chk("fetch_c2", {if_gnt[0], if_done[0]}, 2'b11);
    @(negedge clk);
    chk("fetch_idle", {if_gnt[0], mem_en[0], mem_sel[0], mem_addr[0]},
        {1'b0, 1'b0, 1'b0, 32'h0040_0000});

    // Data write, request dropped after the first access cycle.
    #1;
    push(0, 1'b1, 32'h1001_0004, 1'b1, -1, 1'b0);
    dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 32'h1001_0004;
    @(negedge clk);
    chk("write_c1", {dm_gnt[0], if_gnt[0], mem_sel[0], mem_we[0], mem_en[0], mem_addr[0]},
        {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1001_0004});
    #1 dm_req[0] = 1'b0; dm_we[0] = 1'b0;
    @(negedge clk);
    chk("write_done", {dm_gnt[0], dm_done[0], mem_we[0]}, 3'b111);
    @(negedge clk);
    chk("write_idle", {dm_gnt[0], mem_we[0], mem_sel[0], mem_addr[0]},
        {1'b0, 1'b0, 1'b1, 32'h1001_0004});

    // Both held: IF, DM, IF, DM with one idle cycle between.
    #1;
    push(0, 1'b0, 32'h0000_1000, 1'b0, -1, 1'b0);
    push(0, 1'b1, 32'h2000_0000, 1'b1,  1, 1'b0);
    push(0, 1'b0, 32'h0000_1000, 1'b0,  1, 1'b0);
    push(0, 1'b1, 32'h2000_0000, 1'b1,  1, 1'b0);
    if_req[0] = 1'b1; if_addr[0] = 32'h0000_1000;
    dm_req[0] = 1'b1; dm_addr[0] = 32'h2000_0000; dm_we[0] = 1'b1;
    wait_done(0, 6);
    if_req[0] = 1'b0; dm_req[0] = 1'b0; dm_we[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a LATENCY 4 access, then tie goes to fetch.
    #1;
    push(1, 1'b1, 32'h3000_0040, 1'b0, -1, 1'b1);
    dm_req[1] = 1'b1; dm_addr[1] = 32'h3000_0040;
    @(negedge clk);
    chk("l4_gnt", dm_gnt[1], 1'b1);
    @(negedge clk);
    #1 rst_n[1] = 1'b0; dm_req[1] = 1'b0;
    @(negedge clk);
    chk("l4_reset_outs", {if_gnt[1], dm_gnt[1], if_done[1], dm_done[1], mem_sel[1],
                          mem_en[1], mem_we[1], mem_addr[1]}, 64'd0);
    #1;
    rst_n[1] = 1'b1;
    push(1, 1'b0, 32'h0000_0080, 1'b0, -1, 1'b0);
    push(1, 1'b1, 32'h3000_0044, 1'b0,  1, 1'b0);
    if_req[1] = 1'b1; if_addr[1] = 32'h0000_0080;
    dm_req[1] = 1'b1; dm_addr[1] = 32'h3000_0044;
    @(negedge clk);
    chk("l4_if_first", {if_gnt[1], dm_gnt[1], mem_addr[1]}, {1'b1, 1'b0, 32'h0000_0080});
    #1;
    wait_done(1, 2);
    if_req[1] = 1'b0; dm_req[1] = 1'b0;
    repeat (3) @(negedge clk);

    // LATENCY 1, both requesting: gnt and done coincide, owners alternate.
    #1;
    push(2, 1'b0, 32'h0000_0100, 1'b0, -1, 1'b0);
    push(2, 1'b1, 32'h4000_0200, 1'b0,  1, 1'b0);
    push(2, 1'b0, 32'h0000_0100, 1'b0,  1, 1'b0);
    push(2, 1'b1, 32'h4000_0200, 1'b0,  1, 1'b0);
    if_req[2] = 1'b1; if_addr[2] = 32'h0000_0100;
    dm_req[2] = 1'b1; dm_addr[2] = 32'h4000_0200;
    @(negedge clk);
    chk("l1_c1", {if_gnt[2], if_done[2], dm_gnt[2]}, 3'b110);
    @(negedge clk);
    chk("l1_idle", {if_gnt[2], dm_gnt[2], mem_en[2]}, 3'b000);
    @(negedge clk);
    chk("l1_c3", {dm_gnt[2], dm_done[2], if_gnt[2]}, 3'b110);
    #1;
    wait_done(2, 4);
    if_req[2] = 1'b0; dm_req[2] = 1'b0;

    repeat (4) @(negedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    for (int k = 0; k < 3; k++) chk("no_open_access", act[k], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning memory access duration in cycles; legal range 1..15.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port if_req  input  1  instruction-fetch request.
REQ-005 The block SHALL have port if_addr  input  32  instruction-fetch address.
REQ-006 The block SHALL have port dm_req  input  1  data-memory request.
REQ-007 The block SHALL have port dm_addr  input  32  data-memory address.
REQ-008 The block SHALL have port dm_we  input  1  data-memory write enable.
REQ-009 The block SHALL have port if_gnt  output  1  fetch owns the port.
REQ-010 The block SHALL have port dm_gnt  output  1  data owns the port.
REQ-011 The block SHALL have port if_done  output  1  one-cycle fetch-complete pulse.
REQ-012 The block SHALL have port dm_done  output  1  one-cycle data-complete pulse.
REQ-013 The block SHALL have port mem_sel  output  1  select for the shared 32-bit 2:1 address mux: 0 = fetch, 1 = data.
REQ-014 The block SHALL have port mem_addr  output  32  latched address of current owner.
REQ-015 The block SHALL have port mem_en  output  1  memory access active.
REQ-016 The block SHALL have port mem_we  output  1  write strobe, only for data owner.

Function
REQ-017 The FSM SHALL have two states: IDLE, ACCESS.
REQ-018 In IDLE with one requester active, the block SHALL grant that requester at the next edge.
REQ-019 In IDLE with both active, the block SHALL grant the requester not granted last (round-robin pointer last_own).
REQ-020 At grant, the block SHALL register mem_sel, mem_addr (from winner's address), mem_we (dm_we if data, else 0), and load a 4-bit counter with LATENCY-1.
REQ-021 In ACCESS, the block SHALL hold gnt of owner, mem_en = 1, and mem_sel/mem_addr/mem_we stable; it SHALL ignore requester inputs.
REQ-022 Timing: req sampled at edge T; gnt/mem_en high in cycles T+1..T+LATENCY; done pulse in cycle T+LATENCY (last ACCESS cycle); IDLE in cycle T+LATENCY+1.
REQ-023 The counter SHALL decrement each ACCESS cycle; done SHALL assert when counter = 0; FSM returns to IDLE next edge and updates last_own to owner.
REQ-024 Exactly one IDLE cycle SHALL separate consecutive accesses; no back-to-back grant.
REQ-025 A requester deasserting req mid-access SHALL NOT abort the access; done still pulses.
REQ-026 if_gnt and dm_gnt SHALL never be high together; done SHALL only pulse for current owner.
REQ-027 In IDLE, gnt, done, mem_en, mem_we SHALL be 0; mem_sel and mem_addr SHALL hold last values.
REQ-028 With LATENCY = 1, the block SHALL hold ACCESS for one cycle, with gnt and done in the same cycle.

Reset
REQ-029 With rst_n = 0 at an edge, the block SHALL enter IDLE and clear gnt, done, mem_en, mem_we, mem_sel, mem_addr, counter to 0.
REQ-030 After reset, last_own SHALL be data, so fetch wins the first tie.
REQ-031 Reset mid-ACCESS SHALL abort the access with no done pulse; arbitration resumes in the first cycle after rst_n = 1.

Verification
REQ-032 Reset, then if_req = 1, if_addr = 0x00400000, LATENCY = 2 -> if_gnt = 1 for 2 cycles, mem_sel = 0, mem_addr = 0x00400000, if_done in 2nd cycle.
REQ-033 Both req held high continuously -> grants alternate IF, DM, IF, DM, each separated by one IDLE cycle, IF first.
REQ-034 dm_req = 1, dm_we = 1, dm_addr = 0x10010004 -> mem_sel = 1, mem_we = 1, mem_addr = 0x10010004; mem_we = 0 in following IDLE.
REQ-035 dm_req drops after first ACCESS cycle -> dm_done still pulses at T+LATENCY.
REQ-036 rst_n = 0 in middle of a LATENCY = 4 access -> all outputs 0 next cycle, no done; if_req then granted first.
REQ-037 LATENCY = 1, both requesting -> gnt and done coincide, pattern gnt-idle-gnt-idle with owners alternating.
